cu_fsm: RTL and testbench

//  Multicycle sequencer for the MCU core; pairs with the combinational decoder (cu_dcdr).

---
 rtl/cu_pkg.sv | 26 ++
 rtl/cu_fsm.sv | 133 +++++++++++++
 tb/tb_cu_fsm.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the MCU control unit: sequencer states and the
// opcode/func3 encodings used by cu_fsm and the decoder cu_dcdr.
package cu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } cu_state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_PRIV   = 3'b000;

endpackage

// File: rtl/cu_fsm.sv
// Multicycle sequencer for the MCU core. Steps each instruction through
// FETCH -> EXEC [-> WB] [-> INTR], waiting on memory ready handshakes, and
// takes a pending machine interrupt between instructions.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   opcode, func3             current instruction fields (valid from EXEC)
//   intr, mie                 interrupt request level and mstatus.MIE
//   imem_ready, dmem_ready    memory handshakes
//   pc_write, reg_write       PC load / register file write enables
//   mem_rden1, mem_rden2      instruction fetch / data read strobes
//   mem_we2, csr_we           data write strobe / CSR write enable
//   int_taken, mret_exec      interrupt entry / mret execution pulses
// Outputs are combinational from state and inputs.
module cu_fsm
  import cu_pkg::*;
#(
  parameter int INTR_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       intr,
  input  logic       mie,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       mem_we2,
  output logic       csr_we,
  output logic       int_taken,
  output logic       mret_exec
);

  cu_state_t state_q, state_d;
  logic      intr_pend;
  logic      exec_done;  // EXEC completes this cycle (load never does)
  logic      is_mret;    // mret defers interrupt sampling by one instruction

  assign intr_pend = (INTR_EN != 0) && intr && mie;

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    exec_done = 1'b0;
    is_mret   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_rden1 = 1'b1;
        if (imem_ready) state_d = ST_EXEC;
      end

      ST_EXEC: begin
        exec_done = 1'b1;
        case (opcode)
          OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
          end
          OP_LOAD: begin
            mem_rden2 = 1'b1;
            exec_done = 1'b0;
            state_d   = ST_WB;
          end
          OP_STORE: begin
            // Strobe held across stalls; PC advances only once accepted.
            mem_we2   = 1'b1;
            pc_write  = dmem_ready;
            exec_done = dmem_ready;
          end
          OP_SYS: begin
            pc_write = 1'b1;
            if (func3 == F3_CSRRW) begin
              csr_we    = 1'b1;
              reg_write = 1'b1;
            end else if (func3 == F3_PRIV) begin
              mret_exec = 1'b1;
              is_mret   = 1'b1;
            end
          end
          default: pc_write = 1'b1;  // branch and unknown opcodes
        endcase
        if (exec_done) state_d = (intr_pend && !is_mret) ? ST_INTR : ST_FETCH;
      end

      ST_WB: begin
        mem_rden2 = 1'b1;
        if (dmem_ready) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          state_d   = intr_pend ? ST_INTR : ST_FETCH;
        end
      end

      ST_INTR: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Reset suppresses every strobe, even mid-instruction.
    if (rst) begin
      state_d   = ST_FETCH;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_rden1 = 1'b0;
      mem_rden2 = 1'b0;
      mem_we2   = 1'b0;
      csr_we    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm. Two instances share inputs: one with interrupts
// enabled, one with INTR_EN=0. Each step pushes hand-computed expected output
// vectors to a queue; a monitor pops and compares on the falling edge.
// Vector bit order: {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
//                    csr_we, int_taken, mret_exec}
module tb_cu_fsm;

  localparam logic [7:0] PW = 8'h80, RW = 8'h40, RD1 = 8'h20, RD2 = 8'h10,
                         WE2 = 8'h08, CSR = 8'h04, INT = 8'h02, MRET = 8'h01;

  localparam logic [6:0] ADDI = 7'b0010011, ADD = 7'b0110011, LW = 7'b0000011,
                         SW = 7'b0100011, BR = 7'b1100011, SYS = 7'b1110011,
                         BAD = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst, intr, mie, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [7:0] out1, out0;

  always #5 clk = ~clk;

  cu_fsm #(.INTR_EN(1)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .intr(intr), .mie(mie),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(out1[7]), .reg_write(out1[6]), .mem_rden1(out1[5]), .mem_rden2(out1[4]),
    .mem_we2(out1[3]), .csr_we(out1[2]), .int_taken(out1[1]), .mret_exec(out1[0])
  );

  cu_fsm #(.INTR_EN(0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .intr(intr), .mie(mie),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(out0[7]), .reg_write(out0[6]), .mem_rden1(out0[5]), .mem_rden2(out0[4]),
    .mem_we2(out0[3]), .csr_we(out0[2]), .int_taken(out0[1]), .mret_exec(out0[0])
  );

  logic [7:0] q_e1[$];
  logic [7:0] q_e0[$];
  string      q_nm[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Monitor: outputs are combinational, so compare mid-cycle.
  always @(negedge clk) begin
    if (q_nm.size() != 0) begin
      logic [7:0] e1, e0;
      string nm;
      e1 = q_e1.pop_front();
      e0 = q_e0.pop_front();
      nm = q_nm.pop_front();
      n_tests++;
      if (out1 !== e1) begin
        n_fail++;
        $display("FAIL %s intr_en=1: got %b expected %b", nm, out1, e1);
      end
      n_tests++;
      if (out0 !== e0) begin
        n_fail++;
        $display("FAIL %s intr_en=0: got %b expected %b", nm, out0, e0);
      end
    end
  end

  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic ir,
                      input logic me, input logic im, input logic dm, input logic r,
                      input logic [7:0] e1, input logic [7:0] e0, input string nm);
    opcode = op; func3 = f3; intr = ir; mie = me;
    imem_ready = im; dmem_ready = dm; rst = r;
    q_e1.push_back(e1);
    q_e0.push_back(e0);
    q_nm.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; func3 = '0; intr = 1'b0; mie = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    //    op    f3    ir me im dm rst exp(en=1)      exp(en=0)      name
    step(ADDI, 3'd0, 0, 0, 1, 1, 1, 8'h00,         8'h00,         "reset");
    // 1: addi, two cycles per instruction
    step(ADDI, 3'd0, 0, 0, 1, 0, 0, RD1,           RD1,           "addi_fetch");
    step(ADDI, 3'd0, 0, 0, 1, 0, 0, PW|RW,         PW|RW,         "addi_exec");
    step(ADDI, 3'd0, 0, 0, 0, 1, 0, RD1,           RD1,           "fetch_stall");
    step(ADDI, 3'd0, 0, 0, 1, 0, 0, RD1,           RD1,           "fetch_go");
    step(ADDI, 3'd0, 0, 0, 1, 0, 0, PW|RW,         PW|RW,         "addi_exec2");
    // 2: lw with three stall cycles in WB (dmem_ready ignored in EXEC)
    step(LW,   3'd2, 0, 0, 1, 0, 0, RD1,           RD1,           "lw_fetch");
    step(LW,   3'd2, 0, 0, 1, 1, 0, RD2,           RD2,           "lw_exec");
    step(LW,   3'd2, 0, 0, 1, 0, 0, RD2,           RD2,           "lw_wb_stall1");
    step(LW,   3'd2, 0, 0, 1, 0, 0, RD2,           RD2,           "lw_wb_stall2");
    step(LW,   3'd2, 0, 0, 1, 0, 0, RD2,           RD2,           "lw_wb_stall3");
    step(LW,   3'd2, 0, 0, 1, 1, 0, RD2|RW|PW,     RD2|RW|PW,     "lw_wb_done");
    // 3: sw with two stall cycles
    step(SW,   3'd2, 0, 0, 1, 1, 0, RD1,           RD1,           "sw_fetch");
    step(SW,   3'd2, 0, 0, 0, 0, 0, WE2,           WE2,           "sw_stall1");
    step(SW,   3'd2, 0, 0, 0, 0, 0, WE2,           WE2,           "sw_stall2");
    step(SW,   3'd2, 0, 0, 0, 1, 0, WE2|PW,        WE2|PW,        "sw_done");
    // other EXEC classes
    step(BR,   3'd0, 0, 0, 1, 0, 0, RD1,           RD1,           "br_fetch");
    step(BR,   3'd0, 0, 0, 1, 0, 0, PW,            PW,            "br_exec");
    step(SYS,  3'd1, 0, 0, 1, 0, 0, RD1,           RD1,           "csr_fetch");
    step(SYS,  3'd1, 0, 0, 1, 0, 0, CSR|RW|PW,     CSR|RW|PW,     "csrrw_exec");
    step(SYS,  3'd2, 0, 0, 1, 0, 0, RD1,           RD1,           "sysnop_fetch");
    step(SYS,  3'd2, 0, 0, 1, 0, 0, PW,            PW,            "sysnop_exec");
    step(BAD,  3'd0, 0, 0, 1, 0, 0, RD1,           RD1,           "bad_fetch");
    step(BAD,  3'd0, 0, 0, 1, 0, 0, PW,            PW,            "bad_exec");
    // 4: interrupt after add; INTR_EN=0 instance stays in FETCH
    step(ADD,  3'd0, 1, 1, 1, 0, 0, RD1,           RD1,           "int_fetch");
    step(ADD,  3'd0, 1, 1, 0, 0, 0, PW|RW,         PW|RW,         "int_add_exec");
    step(ADD,  3'd0, 1, 1, 0, 0, 0, INT|PW,        RD1,           "int_taken");
    step(ADD,  3'd0, 1, 1, 0, 0, 0, RD1,           RD1,           "int_no_reenter");
    step(ADD,  3'd0, 1, 0, 1, 0, 0, RD1,           RD1,           "mie0_fetch");
    step(ADD,  3'd0, 1, 0, 1, 0, 0, PW|RW,         PW|RW,         "mie0_exec");
    step(ADD,  3'd0, 1, 0, 0, 0, 0, RD1,           RD1,           "mie0_no_intr");
    // 5: mret defers the pending interrupt by one instruction
    step(SYS,  3'd0, 1, 1, 1, 0, 0, RD1,           RD1,           "mret_fetch");
    step(SYS,  3'd0, 1, 1, 1, 0, 0, MRET|PW,       MRET|PW,       "mret_exec");
    step(ADDI, 3'd0, 1, 1, 1, 0, 0, RD1,           RD1,           "mret_then_fetch");
    step(ADDI, 3'd0, 1, 1, 0, 0, 0, PW|RW,         PW|RW,         "post_mret_exec");
    step(ADDI, 3'd0, 1, 1, 0, 0, 0, INT|PW,        RD1,           "post_mret_intr");
    step(ADDI, 3'd0, 0, 0, 0, 0, 0, RD1,           RD1,           "post_intr_fetch");
    // interrupt out of WB (load EXEC itself never samples it)
    step(LW,   3'd2, 1, 1, 1, 0, 0, RD1,           RD1,           "lwi_fetch");
    step(LW,   3'd2, 1, 1, 0, 0, 0, RD2,           RD2,           "lwi_exec");
    step(LW,   3'd2, 1, 1, 0, 1, 0, RD2|RW|PW,     RD2|RW|PW,     "lwi_wb");
    step(LW,   3'd2, 1, 1, 0, 0, 0, INT|PW,        RD1,           "lwi_intr");
    step(LW,   3'd2, 0, 0, 0, 0, 0, RD1,           RD1,           "lwi_fetch_after");
    // 6: reset in WB, in FETCH stall, and in a store stall
    step(LW,   3'd2, 0, 0, 1, 0, 0, RD1,           RD1,           "rwb_fetch");
    step(LW,   3'd2, 0, 0, 1, 0, 0, RD2,           RD2,           "rwb_exec");
    step(LW,   3'd2, 0, 0, 1, 0, 0, RD2,           RD2,           "rwb_stall");
    step(LW,   3'd2, 0, 0, 1, 1, 1, 8'h00,         8'h00,         "rst_in_wb");
    step(LW,   3'd2, 0, 0, 0, 1, 0, RD1,           RD1,           "after_rst_wb");
    step(LW,   3'd2, 0, 0, 1, 1, 1, 8'h00,         8'h00,         "rst_in_fetch");
    step(LW,   3'd2, 0, 0, 1, 0, 0, RD1,           RD1,           "after_rst_fetch");
    step(SW,   3'd2, 0, 0, 0, 0, 0, WE2,           WE2,           "rsw_stall");
    step(SW,   3'd2, 0, 0, 0, 1, 1, 8'h00,         8'h00,         "rst_in_store");
    step(SW,   3'd2, 0, 0, 0, 1, 0, RD1,           RD1,           "after_rst_store");
    @(negedge clk);
    #1;
    n_tests++;
    if (q_nm.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", q_nm.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
